// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract controller.
// One 4-bit ripple slice is reused over WIDTH/4 cycles, least-significant
// nibble first, with a registered carry linking successive nibbles.
//
// Handshake: start is sampled only in IDLE; an accepted start captures
// a/b/ci/sub, busy is high for the NIB run cycles that follow, and done
// pulses for exactly one cycle with s/co/ovf already valid. s/co/ovf then
// hold until the next done or reset. start outside IDLE is dropped.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic             carry_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic [CW+1:0]    base;
    logic [4:0]       nib_sum;
    logic             ovf_next;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; busy and done are decoded straight from the state.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The single 4-bit slice plus the work word with the current nibble merged,
    // so the final nibble can be registered straight into s on DONE entry.
    always_comb begin
        base      = {cnt, 2'b00};
        nib_sum   = {1'b0, a_reg[base +: 4]} + {1'b0, b_reg[base +: 4]} + {4'b0000, carry_reg};
        work_next = work;
        work_next[base +: 4] = nib_sum[3:0];
        ovf_next  = (a_reg[MSB] == b_reg[MSB]) && (work_next[MSB] != a_reg[MSB]);
    end

    // Operand capture, nibble sequencing and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            work      <= '0;
            s         <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : ci;
                        cnt       <= '0;
                    end
                end
                RUN: begin
                    work      <= work_next;
                    carry_reg <= nib_sum[4];
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        s   <= work_next;
                        co  <= nib_sum[4];
                        ovf <= ovf_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (WIDTH=16).
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    int n_checks;
    int n_fail;

    // Results of the last completed operation, used to check that s/co/ovf hold.
    logic [WIDTH-1:0] last_s;
    logic             last_co;
    logic             last_ovf;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co),
        .ovf   (ovf)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present operands and pulse start so it is sampled at the next rising edge.
    task automatic do_start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                            input logic civ, input logic subv);
        @(negedge clk);
        a     = av;
        b     = bv;
        ci    = civ;
        sub   = subv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Follow an accepted operation: NIB busy cycles, then one done cycle, then idle.
    // With hold_start set, start is kept high with junk operands during RUN.
    task automatic expect_op(input string tag, input logic [WIDTH-1:0] exp_s,
                             input logic exp_co, input logic exp_ovf, input bit hold_start);
        for (int i = 0; i < NIB; i++) begin
            @(negedge clk);
            check_val({tag, "_busy"}, 32'(busy), 32'd1);
            check_val({tag, "_nodone"}, 32'(done), 32'd0);
            check_val({tag, "_hold_s"}, 32'(s), 32'(last_s));
            if (hold_start) begin
                start = 1'b1;
                a     = 16'hAAAA;
                b     = 16'h5555;
                ci    = 1'b1;
                sub   = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check_val({tag, "_done"}, 32'(done), 32'd1);
        check_val({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check_val({tag, "_s"}, 32'(s), 32'(exp_s));
        check_val({tag, "_co"}, 32'(co), 32'(exp_co));
        check_val({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        @(negedge clk);
        check_val({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check_val({tag, "_idle"}, 32'(busy), 32'd0);
        check_val({tag, "_s_held"}, 32'(s), 32'(exp_s));
        last_s   = exp_s;
        last_co  = exp_co;
        last_ovf = exp_ovf;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_s   = '0;
        last_co  = 1'b0;
        last_ovf = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b1;
        sub      = 1'b0;
        a        = 16'h1111;
        b        = 16'h2222;
        ci       = 1'b0;

        // Reset for two edges with start held high: nothing may begin.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_s", 32'(s), 32'h0000);
        check_val("rst_co", 32'(co), 32'd0);
        check_val("rst_ovf", 32'(ovf), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_busy", 32'(busy), 32'd0);

        // Additions.
        do_start(16'h1234, 16'h4321, 1'b0, 1'b0);
        expect_op("add_basic", 16'h5555, 1'b0, 1'b0, 1'b0);
        do_start(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        expect_op("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0);
        do_start(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        expect_op("add_ripple", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Subtractions (ci must be ignored).
        do_start(16'h0005, 16'h0007, 1'b1, 1'b1);
        expect_op("sub_borrow", 16'hFFFE, 1'b0, 1'b0, 1'b0);
        do_start(16'h8000, 16'h0001, 1'b0, 1'b1);
        expect_op("sub_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // start held high with other operands during RUN is ignored.
        do_start(16'h0001, 16'h0001, 1'b0, 1'b0);
        expect_op("busy_prot", 16'h0002, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("busy_prot_no_restart", 32'(busy), 32'd0);
            check_val("busy_prot_no_done", 32'(done), 32'd0);
        end

        // Reset during the second RUN cycle discards the operation.
        do_start(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        check_val("midrst_run1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check_val("midrst_run2_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_done", 32'(done), 32'd0);
        check_val("midrst_s", 32'(s), 32'h0000);
        check_val("midrst_co", 32'(co), 32'd0);
        check_val("midrst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        last_s = '0;
        for (int i = 0; i < NIB + 2; i++) begin
            @(negedge clk);
            check_val("midrst_no_done", 32'(done), 32'd0);
        end
        do_start(16'h000F, 16'h0001, 1'b0, 1'b0);
        expect_op("after_rst", 16'h0010, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
